// File: rtl/pipe_reg_if.sv
// Handshake bundle between an upstream producer, a pipe_reg stage and its downstream consumer.
// Valid/ready: a beat moves on a rising edge exactly when valid and ready are both high.
interface pipe_reg_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  // master: the environment around the stage (drives upstream beats, consumes downstream beats)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the pipeline stage itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and BUBBLE (NOP) fill.
// Define PIPE_REG_SKID_EN to add a skid entry, which makes in_ready a registered output.
module pipe_reg #(
  parameter int           N      = 16,
  parameter logic [N-1:0] BUBBLE = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_reg_if.slave   bus,
  output logic [1:0]  level
);

  // State encoding equals the number of held beats, so level doubles as the FSM debug view.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef PIPE_REG_SKID_EN
  localparam logic [1:0] ST_SKID  = 2'd2;
`endif

  logic [1:0]   r_state;
  logic [N-1:0] r_main;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_pop;

  assign w_out_valid   = (r_state != ST_EMPTY);
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_pop         = w_out_valid & bus.out_ready;

`ifdef PIPE_REG_SKID_EN
  logic [N-1:0] r_skid;
  logic         r_in_ready;

  // Only reset is gated in, so there is no out_ready -> in_ready combinational path.
  assign bus.in_ready = r_in_ready & ~reset;
  assign level        = r_state;
`else
  assign bus.in_ready = ~reset & (~w_out_valid | bus.out_ready);
  assign level        = {1'b0, r_state[0]};
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state    <= ST_EMPTY;
      r_main     <= BUBBLE;
`ifdef PIPE_REG_SKID_EN
      r_skid     <= BUBBLE;
      r_in_ready <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main  <= bus.in_data;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && w_pop) begin
            r_main <= bus.in_data;
`ifdef PIPE_REG_SKID_EN
          end else if (w_accept) begin
            r_skid     <= bus.in_data;
            r_state    <= ST_SKID;
            r_in_ready <= 1'b0;
`endif
          end else if (w_pop) begin
            r_main  <= BUBBLE;
            r_state <= ST_EMPTY;
          end
        end
`ifdef PIPE_REG_SKID_EN
        ST_SKID: begin
          // The older beat leaves main; the skid beat moves up behind it.
          if (w_pop) begin
            r_main     <= r_skid;
            r_skid     <= BUBBLE;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_EMPTY;
          r_main  <= BUBBLE;
        end
      endcase
    end
  end

endmodule
